// File: rtl/bht_branch_predictor_if.sv
// rtl/bht_branch_predictor_if.sv - pipeline-side bundle of the branch history table
// master: pipeline (drives IF/EX lookups, stall, clear_req; observes prediction and stats)
// slave : predictor (drives predict_taken, mispredict, busy, br_count, mis_count)
interface bht_branch_predictor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             predict_taken;
  logic             ex_valid;
  logic             ex_is_branch;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_taken;
  logic             ex_predicted;
  logic             stall;
  logic             mispredict;
  logic             clear_req;
  logic             busy;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport master (
    output if_valid, if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken,
           ex_predicted, stall, clear_req,
    input  predict_taken, mispredict, busy, br_count, mis_count
  );

  modport slave (
    input  if_valid, if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken,
           ex_predicted, stall, clear_req,
    output predict_taken, mispredict, busy, br_count, mis_count
  );
endinterface

// File: rtl/bht_branch_predictor.sv
// rtl/bht_branch_predictor.sv - 2-bit saturating-counter branch history table
// clk, rst_n : clock and asynchronous active-low reset
// bus        : slave side of bht_branch_predictor_if
//   IF lookup  : if_valid, if_pc -> predict_taken (combinational)
//   EX train   : ex_valid, ex_is_branch, ex_pc, ex_taken, ex_predicted, stall -> mispredict
//   clear      : clear_req -> busy for 2^IDX_W cycles
//   statistics : br_count, mis_count
module bht_branch_predictor #(
  parameter int IDX_W   = 6,
  parameter int PC_W    = 32,
  parameter int IDX_LSB = 0,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  bht_branch_predictor_if.slave  bus
);
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [1:0]       table_q [ENTRIES];
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mis_q;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             mis;
  logic             busy;
  logic [1:0]       ex_entry;
  logic [1:0]       ex_next;

  // Only the index slice of each PC matters; the rest is folded here on purpose.
  logic unused_pc;
  assign unused_pc = ^{bus.if_pc, bus.ex_pc};

  assign if_idx  = bus.if_pc[IDX_LSB +: IDX_W];
  assign ex_idx  = bus.ex_pc[IDX_LSB +: IDX_W];
  assign busy    = (state_q == CLEAR);
  assign resolve = bus.ex_valid & bus.ex_is_branch & ~bus.stall;
  assign mis     = resolve & (bus.ex_taken != bus.ex_predicted);

  // Reads the registered table, so a same-cycle train of this index shows next cycle.
  assign bus.predict_taken = bus.if_valid & ~busy & table_q[if_idx][1];
  assign bus.mispredict    = mis;
  assign bus.busy          = busy;
  assign bus.br_count      = br_q;
  assign bus.mis_count     = mis_q;

  assign ex_entry = table_q[ex_idx];

  always_comb begin
    ex_next = ex_entry;
    if (bus.ex_taken) begin
      if (ex_entry != 2'b11) ex_next = ex_entry + 2'b01;
    end else begin
      if (ex_entry != 2'b00) ex_next = ex_entry - 2'b01;
    end
  end

  // Table and clear sequencer share one block: the clear owns the write port
  // while busy, which is why training is dropped during CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
    end else if (state_q == IDLE) begin
      if (resolve) table_q[ex_idx] <= ex_next;
      if (bus.clear_req) begin
        state_q <= CLEAR;
        ptr_q   <= '0;
      end
    end else begin
      table_q[ptr_q] <= 2'b01;
      ptr_q          <= ptr_q + 1'b1;
      if (ptr_q == {IDX_W{1'b1}}) state_q <= IDLE;
    end
  end

  // Statistics ignore busy and clear_req; only stall gates them (through resolve).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (resolve) br_q  <= br_q + 1'b1;
      if (mis)     mis_q <= mis_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_bht_branch_predictor.sv
// tb/tb_bht_branch_predictor.sv - scoreboard bench for bht_branch_predictor
module tb_bht_branch_predictor;
  localparam int IDX_W   = 6;
  localparam int PC_W    = 32;
  localparam int IDX_LSB = 0;
  localparam int CNT_W   = 16;
  localparam int N       = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bht_branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  bht_branch_predictor #(
    .IDX_W(IDX_W), .PC_W(PC_W), .IDX_LSB(IDX_LSB), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit        if_valid;
    bit [31:0] if_pc;
    bit        ex_valid;
    bit        ex_is_branch;
    bit [31:0] ex_pc;
    bit        ex_taken;
    bit        ex_predicted;
    bit        stall;
    bit        clear_req;
    bit        rstn;
  } stim_t;

  typedef struct {
    bit predict;
    bit mispredict;
    bit busy;
    int brc;
    int misc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference state: counters as plain integers 0..3, clear as a countdown.
  int tbl[N];
  int clear_left;
  int brc;
  int misc;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) tbl[i] = 1;
    clear_left = 0;
    brc        = 0;
    misc       = 0;
  endfunction

  function automatic int idx(bit [31:0] pc);
    return int'((pc >> IDX_LSB) % N);
  endfunction

  function automatic stim_t mk(bit [31:0] ifpc, bit exv, bit [31:0] expc,
                               bit tk, bit pr, bit st, bit clr, bit rs);
    stim_t s;
    s.if_valid     = 1'b1;
    s.if_pc        = ifpc;
    s.ex_valid     = exv;
    s.ex_is_branch = exv;
    s.ex_pc        = expc;
    s.ex_taken     = tk;
    s.ex_predicted = pr;
    s.stall        = st;
    s.clear_req    = clr;
    s.rstn         = rs;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   resolve;
    bit   mis;
    @(posedge clk);
    #1;
    bus.if_valid     = s.if_valid;
    bus.if_pc        = s.if_pc;
    bus.ex_valid     = s.ex_valid;
    bus.ex_is_branch = s.ex_is_branch;
    bus.ex_pc        = s.ex_pc;
    bus.ex_taken     = s.ex_taken;
    bus.ex_predicted = s.ex_predicted;
    bus.stall        = s.stall;
    bus.clear_req    = s.clear_req;
    rst_n            = s.rstn;
    if (!s.rstn) model_reset();
    resolve      = s.ex_valid && s.ex_is_branch && !s.stall;
    mis          = resolve && (s.ex_taken != s.ex_predicted);
    e.busy       = (clear_left > 0);
    e.predict    = s.if_valid && !e.busy && (tbl[idx(s.if_pc)] >= 2);
    e.mispredict = mis;
    e.brc        = brc;
    e.misc       = misc;
    sb.push_back(e);
    if (s.rstn) begin
      if (resolve) brc  = (brc + 1) % (1 << CNT_W);
      if (mis)     misc = (misc + 1) % (1 << CNT_W);
      if (clear_left > 0) begin
        tbl[N - clear_left] = 1;
        clear_left--;
      end else begin
        if (resolve) begin
          if (s.ex_taken) tbl[idx(s.ex_pc)] = (tbl[idx(s.ex_pc)] == 3) ? 3 : tbl[idx(s.ex_pc)] + 1;
          else            tbl[idx(s.ex_pc)] = (tbl[idx(s.ex_pc)] == 0) ? 0 : tbl[idx(s.ex_pc)] - 1;
        end
        if (s.clear_req) clear_left = N;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: outputs are settled at the falling edge, half a cycle after the driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("predict_taken", int'(bus.predict_taken), int'(e.predict));
        chk("mispredict",    int'(bus.mispredict),    int'(e.mispredict));
        chk("busy",          int'(bus.busy),          int'(e.busy));
        chk("br_count",      int'(bus.br_count),      e.brc);
        chk("mis_count",     int'(bus.mis_count),     e.misc);
      end
    end
  end

  initial begin
    stim_t s;
    bus.if_valid     = 1'b0;
    bus.if_pc        = '0;
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_pc        = '0;
    bus.ex_taken     = 1'b0;
    bus.ex_predicted = 1'b0;
    bus.stall        = 1'b0;
    bus.clear_req    = 1'b0;
    model_reset();

    repeat (2) step(mk(5, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) step(mk(5, 0, 0, 0, 0, 0, 0, 1));

    step(mk(5, 1, 5, 1, 0, 0, 0, 1));
    step(mk(5, 0, 0, 0, 0, 0, 0, 1));
    repeat (3) step(mk(5, 1, 5, 1, 1, 0, 0, 1));
    step(mk(5, 1, 5, 0, 1, 0, 0, 1));
    step(mk(5, 0, 0, 0, 0, 0, 0, 1));
    step(mk(5, 1, 5, 0, 1, 0, 0, 1));
    step(mk(5, 0, 0, 0, 0, 0, 0, 1));

    repeat (4) step(mk(7, 1, 7, 0, 0, 0, 0, 1));
    step(mk(7, 1, 7, 1, 0, 0, 0, 1));
    step(mk(7, 0, 0, 0, 0, 0, 0, 1));
    step(mk(7 + 64, 0, 0, 0, 0, 0, 0, 1));
    step(mk(7 + 64, 1, 7 + 64, 1, 1, 0, 0, 1));
    step(mk(7, 0, 0, 0, 0, 0, 0, 1));

    step(mk(9, 1, 9, 1, 0, 0, 0, 1));
    step(mk(9, 0, 0, 0, 0, 0, 0, 1));
    step(mk(9, 1, 9, 1, 0, 1, 0, 1));
    step(mk(9, 0, 0, 0, 0, 0, 0, 1));

    repeat (3) step(mk(3, 1, 3, 1, 1, 0, 0, 1));
    step(mk(3, 0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 64; i++) begin
      if (i == 10)      step(mk(3, 1, 0, 1, 0, 0, 0, 1));
      else if (i == 11) step(mk(3, 1, 3, 1, 1, 0, 1, 1));
      else              step(mk(3, 0, 0, 0, 0, 0, 0, 1));
    end
    step(mk(3, 0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1));

    repeat (2) step(mk(40, 1, 40, 1, 1, 0, 0, 1));
    step(mk(40, 0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 20; i++) step(mk(40, 0, 0, 0, 0, 0, 0, 1));
    step(mk(40, 0, 0, 0, 0, 0, 0, 0));
    step(mk(40, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < N; i += 7) step(mk(i, 0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 4000; i++) begin
      s.if_valid     = ($urandom_range(0, 7) != 0);
      s.if_pc        = $urandom_range(0, 255);
      s.ex_valid     = ($urandom_range(0, 3) != 0);
      s.ex_is_branch = ($urandom_range(0, 4) != 0);
      s.ex_pc        = $urandom_range(0, 255);
      s.ex_taken     = $urandom_range(0, 1);
      s.ex_predicted = $urandom_range(0, 1);
      s.stall        = ($urandom_range(0, 5) == 0);
      s.clear_req    = ($urandom_range(0, 250) == 0);
      s.rstn         = ($urandom_range(0, 1500) != 0);
      step(s);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
